// File: rtl/adder_rr_sched_pkg.sv
// rtl/adder_rr_sched_pkg.sv - shared width helpers for the round-robin adder scheduler
//
// Purpose: width helpers used by adder_rr_sched and adder_pipe2.
//   id_width(nreq)     : requester index width, clog2(nreq), at least 1
//   rsp_width(nreq, w) : packed response record width {id, cout, sum}
//   credit_width(d)    : width of a counter holding 0..d
package adder_rr_sched_pkg;

  function automatic int id_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  // Response record layout, LSB first: sum[w-1:0], cout, id.
  function automatic int rsp_width(input int nreq, input int w);
    return id_width(nreq) + w + 1;
  endfunction

  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/adder_pipe2.sv
// rtl/adder_pipe2.sv - two-stage registered adder with valid/id sideband
//
// Purpose: stage 1 registers operands, stage 2 registers the W+1-bit sum.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid, in_id      : issue strobe and requester tag
//   in_a, in_b, in_cin   : operands, captured when in_valid
//   out_valid, out_id    : stage-2 strobe and tag
//   out_sum, out_cout    : stage-2 result a+b+cin
module adder_pipe2 #(
  parameter int W    = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [ID_W-1:0] in_id,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  input  logic            in_cin,
  output logic            out_valid,
  output logic [ID_W-1:0] out_id,
  output logic [W-1:0]    out_sum,
  output logic            out_cout
);

  logic            s1_valid;
  logic [ID_W-1:0] s1_id;
  logic [W-1:0]    s1_a;
  logic [W-1:0]    s1_b;
  logic            s1_cin;
  logic [W:0]      s1_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cin   <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_id  <= in_id;
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_cin <= in_cin;
      end
    end
  end

  assign s1_full = {1'b0, s1_a} + {1'b0, s1_b} + {{W{1'b0}}, s1_cin};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_id   <= s1_id;
        out_sum  <= s1_full[W-1:0];
        out_cout <= s1_full[W];
      end
    end
  end

endmodule

// File: rtl/adder_rr_sched.sv
// rtl/adder_rr_sched.sv - round-robin scheduler sharing a pipelined adder among requesters
//
// Purpose: grants one requester per cycle into adder_pipe2 and returns tagged
// results through a credit-protected first-word-fall-through response FIFO.
// Optional macro ADDER_RR_SCHED_PRIO_EN: requester 0 gets fixed top priority,
// the others round-robin among themselves.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   req_valid/req_ready         : per-requester handshake (ready one-hot or zero)
//   req_a, req_b, req_cin       : packed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready         : response FIFO head handshake
//   rsp_id, rsp_sum, rsp_cout   : head record, zero while rsp_valid is low
module adder_rr_sched
  import adder_rr_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*W-1:0]         req_a,
  input  logic [NREQ*W-1:0]         req_b,
  input  logic [NREQ-1:0]           req_cin,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [id_width(NREQ)-1:0] rsp_id,
  output logic [W-1:0]              rsp_sum,
  output logic                      rsp_cout
);

  localparam int ID_W   = id_width(NREQ);
  localparam int REC_W  = rsp_width(NREQ, W);
  localparam int CRED_W = credit_width(DEPTH);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(DEPTH);
  localparam logic [ID_W-1:0]   LAST_RST = ID_W'(NREQ - 1);

  // ---------------------------------------------------------------- arbiter
  logic [ID_W-1:0]   last_grant_q;
  logic [CRED_W-1:0] credit_q;
  logic [NREQ-1:0]   rr_valid;
  logic [NREQ-1:0]   grant_oh;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_any;
  logic              credit_ok;
  logic              issue;
  logic              upd_last;
  logic              pop;

`ifdef ADDER_RR_SCHED_PRIO_EN
  // Requester 0 is handled outside the rotation, so mask it out here.
  assign rr_valid = req_valid & {{(NREQ-1){1'b1}}, 1'b0};
`else
  assign rr_valid = req_valid;
`endif

  always_comb begin
    int idx;
    idx       = 0;
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
`ifdef ADDER_RR_SCHED_PRIO_EN
    if (req_valid[0]) begin
      grant_oh[0] = 1'b1;
      grant_any   = 1'b1;
    end
`endif
    // Search starts just after the last winner; k == NREQ revisits it last.
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant_q) + k) % NREQ;
      if (!grant_any && rr_valid[idx]) begin
        grant_oh[idx] = 1'b1;
        grant_idx     = ID_W'(idx);
        grant_any     = 1'b1;
      end
    end
  end

  assign credit_ok = (credit_q != '0);
  assign req_ready = (!rst && credit_ok) ? grant_oh : '0;
  assign issue     = |(req_valid & req_ready);

`ifdef ADDER_RR_SCHED_PRIO_EN
  assign upd_last = issue && (grant_idx != '0);
`else
  assign upd_last = issue;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= LAST_RST;
    end else if (upd_last) begin
      last_grant_q <= grant_idx;
    end
  end

  // Credit covers in-flight ops plus FIFO occupancy, so the FIFO cannot overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= CRED_MAX;
    end else if (issue && !pop) begin
      credit_q <= credit_q - CRED_W'(1);
    end else if (pop && !issue) begin
      credit_q <= credit_q + CRED_W'(1);
    end
  end

  // ----------------------------------------------------------------- adder
  logic [W-1:0]    iss_a;
  logic [W-1:0]    iss_b;
  logic            iss_cin;
  logic            p_valid;
  logic [ID_W-1:0] p_id;
  logic [W-1:0]    p_sum;
  logic            p_cout;

  assign iss_a   = req_a[int'(grant_idx)*W +: W];
  assign iss_b   = req_b[int'(grant_idx)*W +: W];
  assign iss_cin = req_cin[grant_idx];

  adder_pipe2 #(
    .W    (W),
    .ID_W (ID_W)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue),
    .in_id     (grant_idx),
    .in_a      (iss_a),
    .in_b      (iss_b),
    .in_cin    (iss_cin),
    .out_valid (p_valid),
    .out_id    (p_id),
    .out_sum   (p_sum),
    .out_cout  (p_cout)
  );

  // ------------------------------------------------------------ response FIFO
  logic [REC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [REC_W-1:0] head;
  logic             push;

  assign push = p_valid && !rst;
  assign pop  = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {p_id, p_cout, p_sum};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  assign rsp_valid = (count_q != '0);
  assign head      = mem[rd_ptr_q];
  assign rsp_sum   = rsp_valid ? head[W-1:0]       : '0;
  assign rsp_cout  = rsp_valid ? head[W]           : 1'b0;
  assign rsp_id    = rsp_valid ? head[W+1 +: ID_W] : '0;

endmodule

// File: tb/tb_adder_rr_sched.sv
// tb/tb_adder_rr_sched.sv - directed and scoreboarded bench for adder_rr_sched
module tb_adder_rr_sched;

  localparam int NREQ  = 4;
  localparam int W     = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_cin;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_sum;
  logic        rsp_cout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adder_rr_sched #(
    .NREQ  (NREQ),
    .W     (W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference grant choice: rotation from last+1, optional fixed priority for 0.
  function automatic logic [3:0] pick(input logic [3:0] v, input int last);
`ifdef ADDER_RR_SCHED_PRIO_EN
    if (v[0]) return 4'b0001;
`endif
    for (int k = 1; k <= 4; k++) begin
      int idx = (last + k) % 4;
`ifdef ADDER_RR_SCHED_PRIO_EN
      if (idx == 0) continue;
`endif
      if (v[idx]) return 4'(1 << idx);
    end
    return 4'b0000;
  endfunction

  // Record {id, cout, sum} for requester i's current operands.
  function automatic logic [6:0] ref_rec(input int i, input logic [15:0] a,
                                         input logic [15:0] b, input logic [3:0] ci);
    logic [4:0] s;
    s = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'b0, ci[i]};
    return {2'(i), s};
  endfunction

  logic [4:0] fair_exp [4] = '{5'h0C, 5'h0D, 5'h0E, 5'h10};
  logic [1:0] drain_ids [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
  logic [6:0] expq [$];

  initial begin
    int hs;
    int last_m;
    int credit_m;
    logic [3:0] exp_rdy;
    logic [6:0] front;
    bit did_pop;

    rst = 1'b1; req_valid = 4'hF; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_rsp", {rsp_valid, rsp_id, rsp_cout, rsp_sum}, 0);

    // Single op: requester 2, F + 1 + 1 = 0x11
    rst = 1'b0; req_valid = 4'b0100;
    req_a = 16'h0F00; req_b = 16'h0100; req_cin = 4'b0100;
    #1;
    check("single_ready", req_ready, 4'b0100);
    @(negedge clk); req_valid = '0; #1;
    check("single_lat1", rsp_valid, 0);
    @(negedge clk); #1;
    check("single_lat2", rsp_valid, 0);
    @(negedge clk); #1;
    check("single_rsp", {rsp_valid, rsp_id, rsp_cout, rsp_sum}, {1'b1, 2'd2, 1'b1, 4'h1});
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    check("single_pop", rsp_valid, 0);

    req_a = 16'h3210; req_b = 16'hCCCC; req_cin = 4'b1000;

`ifdef ADDER_RR_SCHED_PRIO_EN
    do_reset();
    rsp_ready = 1'b1; req_valid = 4'b1001;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("prio_r0", req_ready, 4'b0001);
      @(negedge clk);
    end
    req_valid = 4'b1110;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("prio_rot", req_ready, 1 << (1 + (c % 3)));
      @(negedge clk);
    end
    req_valid = '0;
    repeat (4) @(negedge clk);
`else
    // Fairness with sustained one-per-cycle throughput
    do_reset();
    rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      if (c < 8) check("fair_ready", req_ready, 1 << (c % 4));
      if (c >= 3 && c < 11)
        check("fair_rsp", {rsp_valid, rsp_id, rsp_cout, rsp_sum},
              {1'b1, 2'((c - 3) % 4), fair_exp[(c - 3) % 4]});
      if (c == 11) check("fair_empty", rsp_valid, 0);
      @(negedge clk);
    end

    // Backpressure: exactly DEPTH accepts, then one per freed slot
    do_reset();
    rsp_ready = 1'b0; req_valid = 4'hF; hs = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      hs += $countones(req_valid & req_ready);
      if (c >= 4) check("bp_stall", req_ready, 0);
      @(negedge clk);
    end
    check("bp_count", hs, DEPTH);
    rsp_ready = 1'b1; #1;
    check("bp_no_bypass", req_ready, 0);
    check("bp_head0", {rsp_valid, rsp_id}, {1'b1, 2'd0});
    @(negedge clk); rsp_ready = 1'b0; #1;
    check("bp_one_new", req_ready, 4'b0001);
    check("bp_head1", rsp_id, 1);
    @(negedge clk); rsp_ready = 1'b1; #1;
    check("bp_again_stall", req_ready, 0);
    req_valid = '0;
    for (int d = 0; d < 4; d++) begin
      #1;
      check("bp_drain", {rsp_valid, rsp_id, rsp_cout, rsp_sum},
            {1'b1, drain_ids[d], fair_exp[drain_ids[d]]});
      @(negedge clk);
    end
    #1;
    check("bp_drain_empty", rsp_valid, 0);
`endif

    // Random traffic against a reference arbiter, credit model and scoreboard
    do_reset();
    last_m = 3; credit_m = DEPTH; expq.delete();
    for (int c = 0; c < 100; c++) begin
      req_valid = 4'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
      req_cin = 4'($urandom); rsp_ready = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = (credit_m > 0) ? pick(req_valid, last_m) : 4'b0000;
      check("rnd_ready", req_ready, exp_rdy);
      did_pop = 1'b0;
      if (rsp_valid && rsp_ready) begin
        did_pop = 1'b1;
        if (expq.size() == 0) begin
          check("rnd_spurious", rsp_valid, 0);
        end else begin
          front = expq.pop_front();
          check("rnd_rsp", {rsp_id, rsp_cout, rsp_sum}, front);
        end
      end
      if (exp_rdy != 0) begin
        for (int i = 0; i < 4; i++) begin
          if (exp_rdy[i]) begin
            expq.push_back(ref_rec(i, req_a, req_b, req_cin));
`ifdef ADDER_RR_SCHED_PRIO_EN
            if (i != 0) last_m = i;
`else
            last_m = i;
`endif
          end
        end
        credit_m--;
      end
      if (did_pop) credit_m++;
      @(negedge clk);
    end
    req_valid = '0; rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (rsp_valid) begin
        if (expq.size() == 0) begin
          check("rnd_drain_spurious", rsp_valid, 0);
        end else begin
          front = expq.pop_front();
          check("rnd_drain", {rsp_id, rsp_cout, rsp_sum}, front);
        end
      end
      @(negedge clk);
    end
    check("rnd_lost", expq.size(), 0);

    // Reset while two ops are in flight
    do_reset();
    rsp_ready = 1'b1; req_valid = 4'b0001; #1;
    check("mid_issue0", req_ready, 4'b0001);
    @(negedge clk); req_valid = 4'b0010; #1;
    check("mid_issue1", req_ready, 4'b0010);
    @(negedge clk); rst = 1'b1; req_valid = 4'hF; #1;
    check("mid_rst_ready", req_ready, 0);
    @(negedge clk); #1;
    check("mid_rst_rsp", rsp_valid, 0);
    check("mid_rst_ready2", req_ready, 0);
    @(negedge clk); rst = 1'b0; req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("mid_no_rsp", rsp_valid, 0);
      @(negedge clk);
    end
    req_valid = 4'hF; rsp_ready = 1'b0; hs = 0; #1;
    check("mid_first_r0", req_ready, 4'b0001);
    for (int c = 0; c < 6; c++) begin
      #1;
      hs += $countones(req_valid & req_ready);
      @(negedge clk);
    end
    check("mid_credit_full", hs, DEPTH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
